// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// master is the controller side, slave is the datapath side.
interface multicycle_ctrl_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [31:0]       instr;
    logic              zero;
    logic              ir_load;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
    logic              load_pc;
    logic              pc_src;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [31:0]       imm;
    logic              illegal;

    modport master (
        input  instr,
        input  zero,
        output ir_load,
        output alu_op,
        output alu_src,
        output mem_read,
        output mem_write,
        output mem_to_reg,
        output reg_write,
        output load_pc,
        output pc_src,
        output rs1,
        output rs2,
        output rd,
        output imm,
        output illegal
    );

    modport slave (
        output instr,
        output zero,
        input  ir_load,
        input  alu_op,
        input  alu_src,
        input  mem_read,
        input  mem_write,
        input  mem_to_reg,
        input  reg_write,
        input  load_pc,
        input  pc_src,
        input  rs1,
        input  rs2,
        input  rd,
        input  imm,
        input  illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Five-state (IF/ID/EX/MEM/WB) control unit for a multicycle RV32I datapath.
// Decodes the latched IR into ALU, memory, register-file and PC strobes.
module multicycle_ctrl #(
    parameter int unsigned ADDR_W = 5
) (
    input logic               clk,
    input logic               rst,
    multicycle_ctrl_if.master bus
);

    localparam logic [2:0] StIf  = 3'd0;
    localparam logic [2:0] StId  = 3'd1;
    localparam logic [2:0] StEx  = 3'd2;
    localparam logic [2:0] StMem = 3'd3;
    localparam logic [2:0] StWb  = 3'd4;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluLt  = 4'b0111;
    localparam logic [3:0] AluSrl = 4'b1000;
    localparam logic [3:0] AluSll = 4'b1001;
    localparam logic [3:0] AluSra = 4'b1010;
    localparam logic [3:0] AluXor = 4'b1101;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        zero_q, zero_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic        dec_legal;
    logic [3:0]  dec_op;
    logic        dec_src;
    logic        is_alu;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic [31:0] imm;
    logic [4:0]  rd_field;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign alt      = ir_q[30];
    assign rd_field = ir_q[11:7];

    // ---------------------------------------------------------------
    // Instruction decode (from the latched IR only)
    // ---------------------------------------------------------------
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = AluAdd;
        dec_src   = 1'b0;
        is_alu    = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        is_beq    = 1'b0;
        case (opcode)
            OpR, OpImm: begin
                dec_legal = 1'b1;
                is_alu    = 1'b1;
                dec_src   = (opcode == OpImm);
                case (funct3)
                    3'b000: dec_op = (alt && opcode == OpR) ? AluSub : AluAdd;
                    3'b001: dec_op = AluSll;
                    3'b010: dec_op = AluLt;
                    3'b100: dec_op = AluXor;
                    3'b101: dec_op = alt ? AluSra : AluSrl;
                    3'b110: dec_op = AluOr;
                    3'b111: dec_op = AluAnd;
                    default: begin
                        dec_legal = 1'b0;
                        is_alu    = 1'b0;
                        dec_src   = 1'b0;
                    end
                endcase
            end
            OpLoad: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    is_lw     = 1'b1;
                    dec_src   = 1'b1;
                end
            end
            OpStore: begin
                if (funct3 == 3'b010) begin
                    dec_legal = 1'b1;
                    is_sw     = 1'b1;
                    dec_src   = 1'b1;
                end
            end
            OpBranch: begin
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    is_beq    = 1'b1;
                    dec_op    = AluSub;
                end
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode alone, independent of funct3 legality.
    always_comb begin
        imm = 32'h0;
        case (opcode)
            OpLoad, OpImm: imm = {{20{ir_q[31]}}, ir_q[31:20]};
            OpStore:       imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            OpBranch:      imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                  ir_q[11:8], 1'b0};
            default:       imm = 32'h0;
        endcase
    end

    // ---------------------------------------------------------------
    // Sequencer and state registers
    // ---------------------------------------------------------------
    always_comb begin
        case (state_q)
            StIf:    state_d = StId;
            StId:    state_d = StEx;
            StEx:    state_d = StMem;
            StMem:   state_d = StWb;
            default: state_d = StIf;
        endcase
    end

    always_comb begin
        ir_d      = ir_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (state_q == StIf) begin
            ir_d = bus.instr;
        end
        if (state_q == StEx) begin
            zero_d = bus.zero;
            if (!dec_legal) begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIf;
            ir_q      <= 32'h0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // ---------------------------------------------------------------
    // Per-state outputs
    // ---------------------------------------------------------------
    always_comb begin
        bus.ir_load    = 1'b0;
        bus.alu_op     = AluAdd;
        bus.alu_src    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.load_pc    = 1'b0;
        bus.pc_src     = 1'b0;
        case (state_q)
            StIf: bus.ir_load = 1'b1;
            StEx: begin
                bus.alu_op  = dec_op;
                bus.alu_src = dec_src;
            end
            StMem: begin
                // alu_src stays put so the ALU result feeding the memory address is stable.
                bus.alu_src   = dec_src;
                bus.mem_read  = is_lw;
                bus.mem_write = is_sw;
            end
            StWb: begin
                bus.alu_src    = dec_src;
                bus.load_pc    = 1'b1;
                bus.pc_src     = is_beq & zero_q;
                bus.reg_write  = (is_alu | is_lw) & (rd_field != 5'd0);
                bus.mem_to_reg = is_lw;
            end
            default: ;
        endcase
    end

    assign bus.rs1     = ADDR_W'(ir_q[19:15]);
    assign bus.rs2     = ADDR_W'(ir_q[24:20]);
    assign bus.rd      = ADDR_W'(rd_field);
    assign bus.imm     = imm;
    assign bus.illegal = illegal_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the RV32I datapath. It latches the fetched instruction and sequences it through five states: IF, ID, EX, MEM and WB. It supplies the ALU with its 4-bit `alu_op` and captures the ALU `zero` flag for branch resolution. It also emits register-file, data-memory and PC control strobes, plus the register indices and the sign-extended immediate decoded from the latched instruction.

## Interface
Parameters:
- `ADDR_W`, 5, width of register index outputs.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction word from instruction memory; valid during IF.
- `zero` in 1: ALU zero flag; valid during EX.
- `ir_load` out 1: instruction register loads this cycle (IF).
- `alu_op` out 4: ALU operation code.
- `alu_src` out 1: 0 selects rs2 data, 1 selects `imm` as ALU op2.
- `mem_read` out 1: data-memory read strobe.
- `mem_write` out 1: data-memory write strobe.
- `mem_to_reg` out 1: write-back selects memory data (1) or ALU result (0).
- `reg_write` out 1: register-file write enable.
- `load_pc` out 1: PC register update enable.
- `pc_src` out 1: 0 means PC+4, 1 means PC+`imm`.
- `rs1`, `rs2`, `rd` out ADDR_W each: fields IR[19:15], IR[24:20], IR[11:7].
- `imm` out 32: sign-extended immediate for IR format.
- `illegal` out 1: sticky flag, set on an unsupported instruction.

## Operation
- The internal IR (32b) loads `instr` on the IF-state clock edge. All decode uses IR, not `instr`.
- State sequence: IF→ID→EX→MEM→WB→IF, one cycle each, unconditional, for every instruction (5 cycles/instr).
- ALU op codes: AND 0000, OR 0001, ADD 0010, SUB 0110, LT 0111, SRL 1000, SLL 1001, SRA 1010, XOR 1101.
- Decode by IR[6:0] opcode and funct3:
  - R-type 0110011 (alu_src=0), funct3 mapping:
    - 000: ADD when IR[30]=0, SUB when IR[30]=1.
    - 001: SLL. 010: LT. 100: XOR.
    - 101: SRL when IR[30]=0, SRA when IR[30]=1.
    - 110: OR. 111: AND.
  - I-ALU 0010011 (alu_src=1): same mapping, except:
    - funct3 000 is always ADD (IR[30] ignored).
    - funct3 101 uses IR[30] for SRL/SRA.
  - LOAD 0000011 funct3 010 (lw): ADD, alu_src=1.
  - STORE 0100011 funct3 010 (sw): ADD, alu_src=1.
  - BRANCH 1100011 funct3 000 (beq): SUB, alu_src=0.
  - Any other opcode/funct3 (incl. funct3 011) is illegal. Illegal instructions cause no reg/mem writes, the PC still advances by 4, and `illegal` is set.
- `imm` by opcode:
  - I (LOAD, I-ALU): IR[31:20] sign-extended.
  - S: {IR[31:25],IR[11:7]} sign-extended.
  - B: {IR[31],IR[7],IR[30:25],IR[11:8],0} sign-extended.
  - Otherwise 0.
- Per-state outputs (combinational from state and IR; every unlisted output is 0, and `alu_op`=ADD outside EX):
  - IF: `ir_load`=1.
  - ID: none.
  - EX: `alu_op` and `alu_src` per decode. `zero_q` captures `zero` on the EX edge.
  - MEM: `mem_read`=1 for lw, `mem_write`=1 for sw.
  - WB:
    - `load_pc`=1.
    - `pc_src`=beq & `zero_q`.
    - `reg_write`=1 for R, I-ALU and lw, but forced 0 when `rd`=0.
    - `mem_to_reg`=1 for lw.
- `alu_src` and `mem_to_reg` hold their decode value during the following states so the datapath mux stays stable.

## Timing
- Reset (`rst`=0) forces, asynchronously:
  - state=IF, IR=0, `zero_q`=0, `illegal`=0.
  - Outputs become: `ir_load`=1, `alu_op`=0010, `imm`=0, `rs1`/`rs2`/`rd`=0, all other strobes 0.
- First IR load occurs on the first rising edge after `rst` deasserts.
- Reset asserted in any state aborts the instruction immediately; no WB strobe is emitted for it.
- Each strobe (`mem_read`, `mem_write`, `reg_write`, `load_pc`) is high for exactly one cycle per instruction.
- `zero` is sampled only at the EX edge. Changes in other states have no effect.
- `illegal` is set at the EX edge of the illegal instruction and is cleared only by reset.

## Test plan
- Reset, then release:
  - IF asserted with `ir_load`=1 and `alu_op`=0010 while in reset.
  - State cycles IF,ID,EX,MEM,WB.
  - `load_pc`=1 exactly on cycle 5.
- `add x3,x1,x2` (0x002081B3) and `sub x3,x1,x2` (0x402081B3):
  - EX shows `alu_op` 0010 and 0110 respectively, `alu_src`=0.
  - WB shows `reg_write`=1, `rd`=3.
- `srai x5,x6,3` (0x40335293):
  - EX shows `alu_op`=1010, `alu_src`=1, `imm`[4:0]=3.
  - `addi x0,x0,0` (0x00000013) shows `reg_write`=0 in WB.
- `lw x4,-4(x2)` (0xFFC12203):
  - `imm`=0xFFFFFFFC, `mem_read` high in MEM only.
  - `reg_write`=1 and `mem_to_reg`=1 in WB.
- `sw x5,8(x2)` (0x00512423):
  - `imm`=8, `mem_write` high in MEM only, `reg_write`=0 in WB.
- `beq x1,x2,+16` (0x00208863):
  - With `zero`=1 at EX: WB `pc_src`=1, `imm`=16.
  - With `zero`=0: `pc_src`=0.
- Opcode 0x7F: `illegal` rises after EX with no write strobes and `load_pc`=1.
- Assert reset during EX: outputs return to reset values immediately.
